// File: rtl/pipe_exec_ctl_etom.sv
// Execute-stage control: NZCV flag register, condition evaluation, write/branch gating and the E->M register.
// Define COND_CHECK_EN for full condition-code evaluation; without it every non-flushed instruction executes.
module pipe_exec_ctl_etom #(
  parameter int DW = 32,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          EnM,
  input  logic          FlushE,
  input  logic          FlagWE,
  input  logic          RegWriteE,
  input  logic          MemtoRegE,
  input  logic          MemWriteE,
  input  logic          BranchE,
  input  logic          NoWriteE,
  input  logic [3:0]    CondFieldE,
  input  logic [3:0]    ALUFlags,
  input  logic [DW-1:0] ALUResultE,
  input  logic [DW-1:0] WriteDataE,
  input  logic [AW-1:0] WA3E,
  output logic          CondExE,
  output logic          PCSrcE,
  output logic          RegWriteM,
  output logic          MemtoRegM,
  output logic          MemWriteM,
  output logic [DW-1:0] ALUResultM,
  output logic [DW-1:0] WriteDataM,
  output logic [AW-1:0] WA3M,
  output logic [3:0]    Flags
);

  logic cond_pass;
  logic reg_write_g, mem_write_g, mem_to_reg_g;

`ifdef COND_CHECK_EN
  logic n_f, z_f, c_f, v_f;
  assign {n_f, z_f, c_f, v_f} = Flags;

  // Evaluated against the registered flags only; a flag producer is visible one cycle later.
  always_comb begin
    cond_pass = 1'b1;
    case (CondFieldE)
      4'b0000: cond_pass = z_f;
      4'b0001: cond_pass = !z_f;
      4'b0010: cond_pass = c_f;
      4'b0011: cond_pass = !c_f;
      4'b0100: cond_pass = n_f;
      4'b0101: cond_pass = !n_f;
      4'b0110: cond_pass = v_f;
      4'b0111: cond_pass = !v_f;
      4'b1000: cond_pass = c_f & !z_f;
      4'b1001: cond_pass = !c_f | z_f;
      4'b1010: cond_pass = (n_f == v_f);
      4'b1011: cond_pass = (n_f != v_f);
      4'b1100: cond_pass = !z_f & (n_f == v_f);
      4'b1101: cond_pass = z_f | (n_f != v_f);
      default: cond_pass = 1'b1;
    endcase
  end
`else
  logic unused_cond;
  assign unused_cond = ^CondFieldE;
  assign cond_pass   = 1'b1;
`endif

  assign CondExE      = cond_pass & !FlushE;
  assign PCSrcE       = BranchE & CondExE;
  assign reg_write_g  = RegWriteE & CondExE & !NoWriteE;
  assign mem_write_g  = MemWriteE & CondExE;
  assign mem_to_reg_g = MemtoRegE & CondExE;

  // A stalled instruction never touches the flags, so its condition stays stable across the stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Flags      <= 4'b0000;
      RegWriteM  <= 1'b0;
      MemtoRegM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ALUResultM <= '0;
      WriteDataM <= '0;
      WA3M       <= '0;
    end else if (EnM) begin
      RegWriteM  <= reg_write_g;
      MemtoRegM  <= mem_to_reg_g;
      MemWriteM  <= mem_write_g;
      ALUResultM <= ALUResultE;
      WriteDataM <= WriteDataE;
      WA3M       <= WA3E;
      if (FlagWE && CondExE) Flags <= ALUFlags;
    end
  end

endmodule

// File: tb/tb_pipe_exec_ctl_etom.sv
// Bench for pipe_exec_ctl_etom: directed scenarios plus randomized traffic against an instruction-level model.
module tb_pipe_exec_ctl_etom;
  localparam int DW = 32;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst;
  logic EnM, FlushE, FlagWE, RegWriteE, MemtoRegE, MemWriteE, BranchE, NoWriteE;
  logic [3:0] CondFieldE, ALUFlags;
  logic [DW-1:0] ALUResultE, WriteDataE;
  logic [AW-1:0] WA3E;
  logic CondExE, PCSrcE, RegWriteM, MemtoRegM, MemWriteM;
  logic [DW-1:0] ALUResultM, WriteDataM;
  logic [AW-1:0] WA3M;
  logic [3:0] Flags;

  int n_checks = 0;
  int n_fail = 0;

  // Reference model state
  logic [3:0]    m_flags;
  logic          m_rw, m_mtr, m_mw;
  logic [DW-1:0] m_alu, m_wd;
  logic [AW-1:0] m_wa;

  always #5 clk = ~clk;

  pipe_exec_ctl_etom #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .EnM(EnM), .FlushE(FlushE), .FlagWE(FlagWE),
    .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
    .BranchE(BranchE), .NoWriteE(NoWriteE), .CondFieldE(CondFieldE),
    .ALUFlags(ALUFlags), .ALUResultE(ALUResultE), .WriteDataE(WriteDataE),
    .WA3E(WA3E), .CondExE(CondExE), .PCSrcE(PCSrcE), .RegWriteM(RegWriteM),
    .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM), .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM), .WA3M(WA3M), .Flags(Flags)
  );

  // Condition table written from the architectural definition, flags given as {N,Z,C,V}.
  function automatic logic cond_model(input logic [3:0] code, input logic [3:0] f);
`ifdef COND_CHECK_EN
    logic n, z, c, v;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (code)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return c;
      4'd3:  return !c;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return c && !z;
      4'd9:  return !c || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      default: return 1'b1;
    endcase
`else
    return (code == code) || (f == f);
`endif
  endfunction

  function automatic logic exp_condex();
    return cond_model(CondFieldE, m_flags) && !FlushE;
  endfunction

  task automatic clear_in();
    EnM = 1'b1; FlushE = 0; FlagWE = 0; RegWriteE = 0; MemtoRegE = 0; MemWriteE = 0;
    BranchE = 0; NoWriteE = 0; CondFieldE = 4'b1110; ALUFlags = 0;
    ALUResultE = 0; WriteDataE = 0; WA3E = 0;
  endtask

  task automatic model_reset();
    m_flags = 0; m_rw = 0; m_mtr = 0; m_mw = 0; m_alu = 0; m_wd = 0; m_wa = 0;
  endtask

  // Advance one clock: update the model from the current inputs, then let the DUT take the edge.
  task automatic tick();
    logic ce;
    ce = exp_condex();
    if (EnM) begin
      m_rw  = RegWriteE && ce && !NoWriteE;
      m_mtr = MemtoRegE && ce;
      m_mw  = MemWriteE && ce;
      m_alu = ALUResultE;
      m_wd  = WriteDataE;
      m_wa  = WA3E;
      if (FlagWE && ce) m_flags = ALUFlags;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_in();
    rst = 1'b0;
    ALUResultE = 32'hDEAD_BEEF; WriteDataE = 32'h1234_5678; WA3E = 4'hA;
    RegWriteE = 1; MemWriteE = 1; FlagWE = 1; ALUFlags = 4'b1111;
    tick();
    #2 rst = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if ({RegWriteM, MemtoRegM, MemWriteM} !== 3'b000 || ALUResultM !== '0 || WriteDataM !== '0
        || WA3M !== '0 || Flags !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_regs: ctl=%b alu=%h wd=%h wa=%h flags=%b, want all zero",
               {RegWriteM, MemtoRegM, MemWriteM}, ALUResultM, WriteDataM, WA3M, Flags);
    end
    CondFieldE = 4'b0001; #1;
    n_checks++;
    if (CondExE !== 1'b1) begin
      n_fail++; $display("FAIL reset_ne: CondExE=%b want 1", CondExE);
    end
    CondFieldE = 4'b0000; #1;
    n_checks++;
    if (CondExE !== cond_model(4'b0000, 4'b0000)) begin
      n_fail++; $display("FAIL reset_eq: CondExE=%b want %b", CondExE, cond_model(4'b0000, 4'b0000));
    end
    @(negedge clk);
    rst = 1'b0;
    clear_in();
  endtask

  task automatic test_flag_consume();
    clear_in();
    FlagWE = 1; NoWriteE = 1; RegWriteE = 1; CondFieldE = 4'b1110; ALUFlags = 4'b0100;
    tick();
    n_checks++;
    if (RegWriteM !== 1'b0 || Flags !== 4'b0100) begin
      n_fail++; $display("FAIL cmp: RegWriteM=%b Flags=%b want 0 / 0100", RegWriteM, Flags);
    end
    clear_in();
    BranchE = 1; CondFieldE = 4'b0000; #1;
    n_checks++;
    if (PCSrcE !== (cond_model(4'b0000, m_flags) && 1'b1) || PCSrcE !== 1'b1) begin
      n_fail++; $display("FAIL beq: PCSrcE=%b want 1", PCSrcE);
    end
    tick();
  endtask

  task automatic test_failed_cond();
    clear_in();
    rst = 1'b1; model_reset(); #1; rst = 1'b0;
    CondFieldE = 4'b0000; RegWriteE = 1; MemWriteE = 1; FlagWE = 1; ALUFlags = 4'b1111; #1;
    n_checks++;
    if (CondExE !== exp_condex()) begin
      n_fail++; $display("FAIL failcond_ce: CondExE=%b want %b", CondExE, exp_condex());
    end
    tick();
    n_checks++;
    if (RegWriteM !== m_rw || MemWriteM !== m_mw || Flags !== m_flags) begin
      n_fail++; $display("FAIL failcond_regs: rw=%b mw=%b flags=%b want %b %b %b",
                         RegWriteM, MemWriteM, Flags, m_rw, m_mw, m_flags);
    end
  endtask

  task automatic test_signed();
    logic [3:0] setf [2];
    setf[0] = 4'b1001; setf[1] = 4'b1000;
    for (int s = 0; s < 2; s++) begin
      clear_in();
      FlagWE = 1; CondFieldE = 4'b1110; ALUFlags = setf[s];
      tick();
      n_checks++;
      if (Flags !== setf[s]) begin
        n_fail++; $display("FAIL signed_set%0d: Flags=%b want %b", s, Flags, setf[s]);
      end
      clear_in();
      for (int code = 10; code <= 13; code++) begin
        CondFieldE = 4'(code); #1;
        n_checks++;
        if (CondExE !== exp_condex()) begin
          n_fail++; $display("FAIL signed_cond%0d: flags=%b code=%0d CondExE=%b want %b",
                             s, m_flags, code, CondExE, exp_condex());
        end
      end
    end
  endtask

  task automatic test_stall_flush();
    clear_in();
    RegWriteE = 1; MemWriteE = 1; MemtoRegE = 1; FlagWE = 1; ALUFlags = 4'b0011;
    ALUResultE = 32'hCAFE_0001; WriteDataE = 32'h0BAD_F00D; WA3E = 4'h7;
    tick();
    EnM = 0; ALUFlags = 4'b1100; ALUResultE = 32'h1111_2222; WA3E = 4'h2;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) FlushE = 1;
      #1;
      n_checks++;
      if (CondExE !== exp_condex()) begin
        n_fail++; $display("FAIL stall_ce%0d: CondExE=%b want %b", i, CondExE, exp_condex());
      end
      tick();
      n_checks++;
      if (Flags !== 4'b0011 || RegWriteM !== 1'b1 || MemWriteM !== 1'b1 || ALUResultM !== 32'hCAFE_0001
          || WA3M !== 4'h7) begin
        n_fail++; $display("FAIL stall_hold%0d: flags=%b rw=%b mw=%b alu=%h wa=%h",
                           i, Flags, RegWriteM, MemWriteM, ALUResultM, WA3M);
      end
    end
    EnM = 1; FlushE = 1; BranchE = 1; #1;
    n_checks++;
    if (PCSrcE !== 1'b0) begin
      n_fail++; $display("FAIL flush_pcsrc: PCSrcE=%b want 0", PCSrcE);
    end
    tick();
    n_checks++;
    if (RegWriteM !== 1'b0 || MemWriteM !== 1'b0 || MemtoRegM !== 1'b0 || Flags !== 4'b0011) begin
      n_fail++; $display("FAIL flush_regs: rw=%b mw=%b mtr=%b flags=%b want 0 0 0 0011",
                         RegWriteM, MemWriteM, MemtoRegM, Flags);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      EnM        = ($urandom_range(0, 3) != 0);
      FlushE     = ($urandom_range(0, 4) == 0);
      FlagWE     = 1'($urandom);
      RegWriteE  = 1'($urandom);
      MemtoRegE  = 1'($urandom);
      MemWriteE  = 1'($urandom);
      BranchE    = 1'($urandom);
      NoWriteE   = ($urandom_range(0, 3) == 0);
      CondFieldE = 4'($urandom);
      ALUFlags   = 4'($urandom);
      ALUResultE = $urandom;
      WriteDataE = $urandom;
      WA3E       = AW'($urandom);
      if (i == 200) begin
        rst = 1'b1; model_reset(); #1;
        n_checks++;
        if (Flags !== 4'b0 || RegWriteM !== 1'b0 || ALUResultM !== '0) begin
          n_fail++; $display("FAIL rand_rst: flags=%b rw=%b alu=%h", Flags, RegWriteM, ALUResultM);
        end
        rst = 1'b0;
      end
      #1;
      n_checks++;
      if (CondExE !== exp_condex() || PCSrcE !== (BranchE && exp_condex())) begin
        n_fail++; $display("FAIL rand_comb%0d: ce=%b pcs=%b want %b %b", i, CondExE, PCSrcE,
                           exp_condex(), BranchE && exp_condex());
      end
      tick();
      n_checks++;
      if ({RegWriteM, MemtoRegM, MemWriteM} !== {m_rw, m_mtr, m_mw} || ALUResultM !== m_alu
          || WriteDataM !== m_wd || WA3M !== m_wa || Flags !== m_flags) begin
        n_fail++;
        $display("FAIL rand_reg%0d: ctl=%b alu=%h wd=%h wa=%h fl=%b want %b %h %h %h %b", i,
                 {RegWriteM, MemtoRegM, MemWriteM}, ALUResultM, WriteDataM, WA3M, Flags,
                 {m_rw, m_mtr, m_mw}, m_alu, m_wd, m_wa, m_flags);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    clear_in();
    model_reset();
    #12;
    test_reset();
    test_flag_consume();
    test_failed_cond();
    test_signed();
    test_stall_flush();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
